// File: rtl/arb_mux.sv
// N-channel valid/ready arbiter (fixed priority or round-robin) feeding a single output register.
// Latency 1 cycle; in_ready only when the output register is empty or draining this cycle.
module arb_mux #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = 1,
    localparam int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    input  logic               out_ready
);

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SW-1:0]      r_out_sel;
    logic [SW-1:0]      r_ptr;

    logic [WIDTH-1:0]   w_chan [N];
    logic [N-1:0]       w_grant;
    logic [SW-1:0]      w_gidx;
    logic [SW-1:0]      w_cand;
    logic [SW-1:0]      w_base;
    logic               w_found;
    logic               w_load_en;
    logic               w_xfer;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign w_chan[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // (base + k) mod N for k < N, without relying on N being a power of two
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return SW'(s);
    endfunction

    assign w_base    = (MODE == 1) ? r_ptr : '0;
    assign w_load_en = !r_out_valid || out_ready;

    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = wrap_add(w_base, k);
            if (!w_found && in_valid[w_cand]) begin
                w_found         = 1'b1;
                w_gidx          = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
    end

    assign in_ready = rst ? '0 : (w_grant & {N{w_load_en}});
    assign w_xfer   = |in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_chan[w_gidx];
            r_out_sel   <= w_gidx;
            if (MODE == 1) r_ptr <= wrap_add(w_gidx, 1);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a fixed-priority and a round-robin instance share one stimulus stream,
// each checked every cycle against a queue-free behavioural model plus literal scenario checks.
module tb_arb_mux;
    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;

    logic [N-1:0]   rdy_fp, rdy_rr;
    logic           ov_fp, ov_rr;
    logic [W-1:0]   od_fp, od_rr;
    logic [1:0]     os_fp, os_rr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(W), .N(N), .MODE(0)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_fp),
        .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp), .out_ready(out_ready));

    arb_mux #(.WIDTH(W), .N(N), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_rr),
        .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr), .out_ready(out_ready));

    // model state, index 0 = fixed priority, 1 = round-robin
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    logic [1:0]   m_sel   [2];
    int           m_ptr;
    logic         m_init = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int m);
        int base;
        int c;
        base = (m == 1) ? m_ptr : 0;
        for (int k = 0; k < N; k++) begin
            c = (base + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        int g;
        if (rst) return '0;
        if (m_valid[m] && !out_ready) return '0;
        g = pick(m);
        if (g < 0) return '0;
        return N'(1 << g);
    endfunction

    always @(posedge clk) begin
        int g;
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_valid[m] = 1'b0;
                m_data[m]  = '0;
                m_sel[m]   = '0;
            end
            m_ptr  = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            for (int m = 0; m < 2; m++) begin
                g = pick(m);
                if ((!m_valid[m] || out_ready) && g >= 0) begin
                    m_valid[m] = 1'b1;
                    m_data[m]  = in_data[g*W +: W];
                    m_sel[m]   = 2'(g);
                    if (m == 1) m_ptr = (g + 1) % N;
                end else if (out_ready) begin
                    m_valid[m] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("fp_in_ready",  64'(rdy_fp), 64'(exp_ready(0)));
            chk("rr_in_ready",  64'(rdy_rr), 64'(exp_ready(1)));
            chk("fp_out_valid", 64'(ov_fp),  64'(m_valid[0]));
            chk("rr_out_valid", 64'(ov_rr),  64'(m_valid[1]));
            chk("fp_out_data",  64'(od_fp),  64'(m_data[0]));
            chk("rr_out_data",  64'(od_rr),  64'(m_data[1]));
            chk("fp_out_sel",   64'(os_fp),  64'(m_sel[0]));
            chk("rr_out_sel",   64'(os_rr),  64'(m_sel[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_all_data(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) in_data[i*W +: W] = base + W'(i);
    endtask

    initial begin
        int exp_seq [8];
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};

        // reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(ov_rr), 64'h0);
        chk("rst_out_data",  64'(od_rr), 64'h0);
        chk("rst_out_sel",   64'(os_rr), 64'h0);
        chk("rst_in_ready",  64'(rdy_rr), 64'h0);
        rst = 1'b0;

        // round-robin full rotation
        in_valid = 4'b1111;
        set_all_data(32'hA0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("s1_sel",   64'(os_rr), 64'(exp_seq[i]));
            chk("s1_data",  64'(od_rr), 64'(32'hA0 + exp_seq[i]));
            chk("s1_valid", 64'(ov_rr), 64'h1);
        end

        // fixed priority with channels 1 and 3 requesting
        do_reset();
        in_valid = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s2_in_ready", 64'(rdy_fp), 64'h2);
            tick();
            chk("s2_sel", 64'(os_fp), 64'h1);
        end

        // backpressure hold then drain+refill
        do_reset();
        in_valid = 4'b0100;
        in_data[2*W +: W] = 32'hDEADBEEF;
        out_ready = 1'b0;
        tick();
        in_data[2*W +: W] = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s3_hold_valid", 64'(ov_rr), 64'h1);
            chk("s3_hold_data",  64'(od_rr), 64'hDEADBEEF);
            chk("s3_hold_sel",   64'(os_rr), 64'h2);
            chk("s3_hold_rdy",   64'(rdy_rr), 64'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("s3_refill_rdy", 64'(rdy_rr), 64'h4);
        tick();
        chk("s3_refill_data",  64'(od_rr), 64'h12345678);
        chk("s3_refill_valid", 64'(ov_rr), 64'h1);

        // wrap and skip: ptr=3 after a channel-2 transfer
        do_reset();
        in_valid = 4'b0100;
        out_ready = 1'b1;
        tick();
        in_valid = 4'b0101;
        #1;
        chk("s4_wrap_rdy", 64'(rdy_rr), 64'h1);
        tick();
        chk("s4_wrap_sel", 64'(os_rr), 64'h0);
        chk("s4_skip_rdy", 64'(rdy_rr), 64'h4);
        tick();
        chk("s4_skip_sel", 64'(os_rr), 64'h2);

        // reset mid-operation with ptr=2 and a held output
        do_reset();
        in_valid = 4'b0010;
        set_all_data(32'h55);
        out_ready = 1'b0;
        tick();
        in_valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk("s5_rst_rdy", 64'(rdy_rr), 64'h0);
        tick();
        chk("s5_valid", 64'(ov_rr), 64'h0);
        chk("s5_data",  64'(od_rr), 64'h0);
        chk("s5_sel",   64'(os_rr), 64'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("s5_first_grant", 64'(rdy_rr), 64'h1);

        // idle inputs keep ptr
        do_reset();
        in_valid = 4'b0001;
        out_ready = 1'b1;
        tick();
        in_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s6_valid", 64'(ov_rr), 64'h0);
        end
        in_valid = 4'b1111;
        #1;
        chk("s6_ptr_kept", 64'(rdy_rr), 64'h2);

        // randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 2000; i++) begin
            tick();
            in_valid = 4'($urandom);
            for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
        end
        rst = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter MODE, default 1; 0 selects fixed priority (lowest index wins), 1 selects round-robin.
REQ-004 Localparam SW = clog2(N), width of the channel-index fields.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 in_valid  input  N  bit i high means channel i presents data.
REQ-008 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  N  bit i high means channel i's data is accepted this cycle.
REQ-010 out_valid  output  1  the output register holds valid data.
REQ-011 out_data  output  WIDTH  the registered selected data.
REQ-012 out_sel  output  SW  index of the channel that out_data came from.
REQ-013 out_ready  input  1  the downstream consumer accepts out_data this cycle.

Function
REQ-014 A transfer on any port occurs in a cycle where valid and ready are both high at the rising edge.
REQ-015 load_en = !out_valid || out_ready; the output register shall accept new data only when load_en is high.
REQ-016 grant shall be combinational and one-hot or zero, and shall be zero when no in_valid bit is set.
REQ-017 in_ready shall equal grant AND load_en, replicated per channel.
REQ-018 At most one in_ready bit shall be high in any cycle, and no in_ready bit shall be high for a channel whose in_valid is low.
REQ-019 MODE 0: the grant shall go to the lowest-indexed channel with in_valid high.
REQ-020 MODE 1: the grant shall go to the first channel with in_valid high, searching ptr, ptr+1, ... N-1, 0, ... ptr-1, where ptr is an internal SW-bit register.
REQ-021 MODE 1: on a transfer from channel g, ptr shall become (g+1) mod N; on wrap from N-1, ptr shall become 0.
REQ-022 MODE 1: ptr shall be unchanged in any cycle with no input transfer, including cycles where load_en is low.
REQ-023 On an input transfer from channel g, the next cycle shall have out_valid=1, out_data=channel g's data and out_sel=g; latency is 1 cycle.
REQ-024 If out_ready=1, out_valid=1 and no input is valid, out_valid shall become 0 next cycle.
REQ-025 If out_ready=1, out_valid=1 and some input is valid, the register shall be drained and refilled in the same cycle, sustaining 1 transfer per cycle.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_sel shall hold stable and all in_ready bits shall be 0.
REQ-027 out_data and out_sel shall not change except on an input transfer.
REQ-028 An input's in_valid/in_data shall not need to be held for the grant logic; dropping in_valid before a transfer shall be legal and shall never cause a transfer.
REQ-029 MODE 1 fairness: with all N inputs continuously valid and out_ready=1, each channel shall be granted exactly once in every N consecutive transfers.

Reset
REQ-030 While rst=1 at a clock edge: out_valid=0, out_data=0, out_sel=0 and ptr=0 at the next cycle.
REQ-031 In any cycle where rst=1, in_ready shall be all zero and no transfer shall be recorded, and data held mid-operation shall be discarded.
REQ-032 The first cycle after rst deasserts shall behave as an empty register with ptr=0.

Verification
REQ-033 Scenario 1 (MODE 1, N=4, WIDTH=32): all in_valid=1, in_data[i]=0xA0+i, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with matching out_data, one transfer per cycle.
REQ-034 Scenario 2 (MODE 0): in_valid=4'b1010 held -> every transfer is from channel 1, and channel 3 never gets in_ready.
REQ-035 Scenario 3 (backpressure): fill the register from channel 2 with 0xDEADBEEF, hold out_ready=0 for 5 cycles -> out_valid=1, data stable, in_ready=0 throughout; raise out_ready -> drain plus refill in the same cycle.
REQ-036 Scenario 4 (wrap and skip, MODE 1): ptr=3, in_valid=4'b0101 -> grant to channel 0, then ptr=1 -> next grant to channel 2.
REQ-037 Scenario 5 (reset mid-operation): assert rst while out_valid=1, ptr=2 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_sel=0, in_ready=0; after release, with all inputs valid, first grant goes to channel 0.
REQ-038 Scenario 6 (empty): in_valid=0 for 4 cycles with out_ready=1 -> out_valid=0 and ptr unchanged.
